// File: rtl/gray_pkg.sv
// Shared types and constants for the grayscale frame controller.
// Optional feature macro: GRAY_WEIGHTED_EN (selects luma-weighted conversion).
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Luma weights; they sum to 256 so the top byte of the sum never overflows
    localparam int W_R = 77;
    localparam int W_G = 150;
    localparam int W_B = 29;

    // Field positions inside a packed {R,G,B} pixel
    localparam int R_HI = 23;
    localparam int R_LO = 16;
    localparam int G_HI = 15;
    localparam int G_LO = 8;
    localparam int B_HI = 7;
    localparam int B_LO = 0;

endpackage

// File: rtl/gray_frame_ctrl_if.sv
// Pixel stream bundle: RGB input stream and gray output stream with frame markers.
// The controller uses the slave view; the surrounding environment uses master.
interface gray_frame_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_rgb;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_gray;
    logic        out_sof;
    logic        out_eol;
    logic        out_eof;

    modport slave (
        input  in_valid, in_rgb, out_ready,
        output in_ready, out_valid, out_gray, out_sof, out_eol, out_eof
    );

    modport master (
        output in_valid, in_rgb, out_ready,
        input  in_ready, out_valid, out_gray, out_sof, out_eol, out_eof
    );

endinterface

// File: rtl/gray_conv_stage.sv
// Single enable-gated register stage converting RGB to 8-bit gray.
// Optional feature macro: GRAY_WEIGHTED_EN (77/150/29 luma weights instead of equal /3 weights).
module gray_conv_stage
    import gray_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [23:0] rgb,
    output logic [7:0]  gray
);

    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;

    assign r = rgb[R_HI:R_LO];
    assign g = rgb[G_HI:G_LO];
    assign b = rgb[B_HI:B_LO];

`ifdef GRAY_WEIGHTED_EN
    logic [15:0] sum_q;

    // Register the weighted luma sum; its top byte is the gray value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (en) begin
            sum_q <= 16'(W_R * int'(r) + W_G * int'(g) + W_B * int'(b));
        end
    end

    assign gray = sum_q[15:8];
`else
    logic [7:0] r3_q;
    logic [7:0] g3_q;
    logic [7:0] b3_q;

    // Register each channel divided by three; the sum of three 85s is at most 255
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_q <= '0;
            g3_q <= '0;
            b3_q <= '0;
        end else if (en) begin
            r3_q <= r / 8'd3;
            g3_q <= g / 8'd3;
            b3_q <= b / 8'd3;
        end
    end

    assign gray = r3_q + g3_q + b3_q;
`endif

endmodule

// File: rtl/gray_frame_ctrl.sv
// Frame sequencer: accepts one frame of RGB pixels after start, converts them through a
// stallable one-stage pipe and emits gray pixels with SOF/EOL/EOF markers, then pulses done.
// Optional feature macro: GRAY_WEIGHTED_EN (handled inside gray_conv_stage).
module gray_frame_ctrl
    import gray_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 9
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    gray_frame_ctrl_if.slave   px
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             pipe_valid_q;
    logic             sof_q;
    logic             eol_q;
    logic             eof_q;
    logic             accept;
    logic             drain;
    logic             at_sof;
    logic             at_eol;
    logic             at_eof;

    // Marker conditions for the pixel at the current counter position
    assign at_sof = (col_q == '0) && (row_q == '0);
    assign at_eol = (col_q == COL_LAST);
    assign at_eof = at_eol && (row_q == ROW_LAST);

    // The pipe can take a new pixel when empty or when it drains in the same cycle
    assign px.in_ready = (state_q == RUN) && (!pipe_valid_q || px.out_ready);
    assign accept      = px.in_valid && px.in_ready;
    assign drain       = pipe_valid_q && px.out_ready;

    assign px.out_valid = pipe_valid_q;
    assign px.out_sof   = sof_q;
    assign px.out_eol   = eol_q;
    assign px.out_eof   = eof_q;

    assign busy = (state_q == RUN) || (state_q == FLUSH);
    assign done = (state_q == DONE);

    gray_conv_stage u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .rgb   (px.in_rgb),
        .gray  (px.out_gray)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: frame runs until the last pixel is accepted, then waits for its EOF handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && at_eof) state_d = FLUSH;
            FLUSH:   if (drain && eof_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Column/row position of the next pixel to be accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (state_q == IDLE && start) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (at_eol) begin
                col_q <= '0;
                row_q <= at_eof ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Pipe occupancy and markers travel with the registered pixel data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            eol_q        <= 1'b0;
            eof_q        <= 1'b0;
        end else if (accept) begin
            pipe_valid_q <= 1'b1;
            sof_q        <= at_sof;
            eol_q        <= at_eol;
            eof_q        <= at_eof;
        end else if (drain) begin
            pipe_valid_q <= 1'b0;
        end
    end

endmodule
